// File: rtl/bus_target_responder.sv
// Memory-mapped 32-bit target for the multiplexed-AD 68030-style bus.
// Latches the address on AS, then serves a read or write and ends with DSACK or BERR.
`timescale 1ns/1ps
module bus_target_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h20200000,
  parameter int          ADDR_BITS   = 4,
  parameter int          WAIT_STATES = 2,
  parameter int          TIMEOUT     = 64
) (
  input  logic        pin_clk_16M,
  input  logic        pin_reset_in,
  input  logic        pin_as,
  input  logic        pin_ds,
  input  logic        pin_rw,
  input  logic [31:0] pin_ad_in,
  output logic [31:0] pin_ad_out,
  output logic        pin_ad_oe,
  output logic        pin_dsack0,
  output logic        pin_dsack1,
  output logic        pin_berr,
  output logic [15:0] hit_count
);

  localparam int DEPTH   = 2 ** ADDR_BITS;
  localparam int TAG_LSB = ADDR_BITS + 2;

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, ACK, ERR} state_t;

  state_t                 state, state_n;
  logic                   as_m, as_s, ds_m, ds_s, rw_m, rw_s;
  logic [31:0]            ad_m, ad_s;
  logic [31:2]            addr_q, addr_n;
  logic                   rw_q, rw_n;
  logic [15:0]            tmo_cnt, tmo_n;
  logic [7:0]             wait_cnt, wait_n;
  logic                   mem_we, oe_n, dsack_q;
  logic [ADDR_BITS-1:0]   idx;
  logic                   hit;
  logic [31:0]            mem [DEPTH];

  assign idx        = addr_q[TAG_LSB-1:2];
  assign hit        = (addr_q[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign pin_dsack0 = dsack_q;
  assign pin_dsack1 = dsack_q;

  always_ff @(posedge pin_clk_16M or negedge pin_reset_in) begin
    if (!pin_reset_in) begin
      // NOTE: strobes reset to their idle level so the FSM never sees a phantom cycle as reset releases.
      as_m <= 1'b1;
      as_s <= 1'b1;
      ds_m <= 1'b1;
      ds_s <= 1'b1;
      rw_m <= 1'b0;
      rw_s <= 1'b0;
      ad_m <= '0;
      ad_s <= '0;
    end else begin
      as_m <= pin_as;
      as_s <= as_m;
      ds_m <= pin_ds;
      ds_s <= ds_m;
      rw_m <= pin_rw;
      rw_s <= rw_m;
      ad_m <= pin_ad_in;
      ad_s <= ad_m;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_n = state;
    addr_n  = addr_q;
    rw_n    = rw_q;
    tmo_n   = tmo_cnt;
    wait_n  = wait_cnt;
    mem_we  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!as_s) begin
          if (ds_s) begin
            state_n = ADDR;
            addr_n  = ad_s[31:2];
            rw_n    = rw_s;
            tmo_n   = '0;
          end else begin
            state_n = ERR;
          end
        end
      end
      ADDR: begin
        if (as_s) begin
          state_n = IDLE;
        end else if (!ds_s) begin
          if (!hit) begin
            state_n = ERR;
          end else begin
            mem_we = !rw_q;
            if (WAIT_STATES == 0) begin
              state_n = ACK;
            end else begin
              state_n = WAIT;
              wait_n  = 8'(WAIT_STATES);
            end
          end
        end else if (tmo_cnt == 16'(TIMEOUT - 1)) begin
          state_n = ERR;
        end else begin
          tmo_n = tmo_cnt + 16'd1;
        end
      end
      WAIT: begin
        // Leave one count early: DSACK is registered from the next state.
        if (as_s) begin
          state_n = IDLE;
        end else if (wait_cnt <= 8'd1) begin
          state_n = ACK;
        end else begin
          wait_n = wait_cnt - 8'd1;
        end
      end
      ACK, ERR: begin
        if (as_s && ds_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    oe_n = ((state_n == WAIT) || (state_n == ACK)) && rw_q;
  end

  always_ff @(posedge pin_clk_16M or negedge pin_reset_in) begin
    if (!pin_reset_in) begin
      state      <= IDLE;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      tmo_cnt    <= '0;
      wait_cnt   <= '0;
      pin_ad_out <= '0;
      pin_ad_oe  <= 1'b0;
      dsack_q    <= 1'b1;
      pin_berr   <= 1'b1;
      hit_count  <= '0;
    end else begin
      state      <= state_n;
      addr_q     <= addr_n;
      rw_q       <= rw_n;
      tmo_cnt    <= tmo_n;
      wait_cnt   <= wait_n;
      pin_ad_out <= oe_n ? mem[idx] : '0;
      pin_ad_oe  <= oe_n;
      dsack_q    <= (state_n != ACK);
      pin_berr   <= (state_n != ERR);
      if ((state_n == ACK) && (state != ACK)) hit_count <= hit_count + 16'd1;
    end
  end

  // NOTE: the register file is flops, so it can and must clear on reset.
  always_ff @(posedge pin_clk_16M or negedge pin_reset_in) begin
    if (!pin_reset_in) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[idx] <= ad_s;
    end
  end

endmodule

// File: doc/bus_target_responder.md
Name: bus_target_responder

Overview:
- Simple 32-bit memory-mapped slave on the multiplexed-AD 68030-style bus that busdebugger_serial observes.
- Latches the address on AS, then completes the cycle:
  - read: drives data onto AD;
  - write: captures data from AD;
  - terminates with DSACK0/DSACK1 (32-bit port) or BERR.
- Used as the responder end for bus bring-up and for feeding known traffic to the debugger.

Parameters:
- BASE_ADDR, 32'h20200000, base of mapped window; compare uses bits [31:ADDR_BITS+2].
- ADDR_BITS, 4, word-index width; DEPTH = 2**ADDR_BITS 32-bit registers.
- WAIT_STATES, 2, extra clocks between data phase start and DSACK (0..255).
- TIMEOUT, 64, clocks in ADDR without DS before BERR (1..65535).

Ports:
- pin_clk_16M  in  1  system clock; all logic on rising edge.
- pin_reset_in  in  1  asynchronous active-low reset.
- pin_as  in  1  address strobe, active low, asynchronous to pin_clk_16M.
- pin_ds  in  1  data strobe, active low.
- pin_rw  in  1  1=read, 0=write.
- pin_ad_in  in  32  multiplexed address/data input.
- pin_ad_out  out  32  read data.
- pin_ad_oe  out  1  1=drive pin_ad_out onto bus.
- pin_dsack0  out  1  active low.
- pin_dsack1  out  1  active low; always equal to pin_dsack0.
- pin_berr  out  1  active low bus error.
- hit_count  out  16  completed DSACK cycles, wraps 16'hFFFF->0.

Behaviour:

Synchronisation and reset:
- pin_as, pin_ds, pin_rw and pin_ad_in each pass through a 2-FF synchroniser (as_s, ds_s, rw_s, ad_s). Control and data stay aligned.
- All outputs are registered.
- Reset values: pin_ad_out=0, pin_ad_oe=0, pin_dsack0/1=1, pin_berr=1, hit_count=0, all registers=0, state=IDLE.

State machine:
- IDLE
  - When as_s==0 and ds_s==1: latch ad_s as address, latch rw_s, clear timeout counter, go to ADDR.
  - When as_s==0 and ds_s==0 in the same cycle (no address phase seen): go to ERR.
- ADDR
  - as_s==1: return to IDLE (abandoned cycle, no response).
  - Otherwise, on the first cycle T with ds_s==0:
    - Unmapped address (upper bits differ from BASE_ADDR): go to ERR.
    - Mapped write: write ad_s to reg[addr[ADDR_BITS+1:2]] at T.
    - Mapped read or write: load wait counter with WAIT_STATES and go to WAIT.
  - Timeout counter reaches TIMEOUT with ds_s still 1: go to ERR.
- WAIT
  - Read: pin_ad_out = reg[index] and pin_ad_oe=1 from T+1. Data is stable before DSACK.
  - Counter decrements each cycle; at 0 go to ACK. DSACK asserts at cycle T+1+WAIT_STATES.
  - as_s==1 in WAIT: abort to IDLE, pin_ad_oe=0 next cycle, no DSACK, hit_count unchanged.
- ACK
  - pin_dsack0/1=0; hit_count increments once, on entry.
  - Hold until as_s==1 and ds_s==1, then IDLE. On that transition all outputs deassert: dsack=1, oe=0.
- ERR
  - pin_berr=0, pin_ad_oe=0.
  - Hold until as_s==1 and ds_s==1, then IDLE, berr=1.

Rules:
- pin_dsack and pin_berr are never asserted together.
- pin_ad_oe is never 1 during a write cycle.
- Back-to-back cycles: a new AS fall is only accepted from IDLE. At least one IDLE cycle separates cycles.
- Reset asserted mid-cycle immediately releases all outputs and clears the registers.

Test Plan:
1. Write then read:
   - Write: AS low with AD=32'h20200008, DS low with AD=32'hDEADBEEF, rw=0 -> DSACK0/1 low exactly WAIT_STATES+1 clocks after ds_s low; pin_ad_oe stays 0.
   - Read: same address, rw=1 -> pin_ad_out=32'hDEADBEEF with oe=1 at least 1 clock before DSACK.
   - hit_count=2 after both cycles.
2. WAIT_STATES=0 vs 5 -> DSACK latency of 1 and 6 clocks after ds_s low respectively; release 1 clock after AS/DS high.
3. Unmapped: AD=32'h12345678, DS low -> pin_berr low at T+1, no DSACK, oe=0, hit_count unchanged; berr high after AS/DS release.
4. Timeout: AS low and DS held high for TIMEOUT=64 clocks -> BERR at 64; early AS release at clock 10 -> IDLE, no response.
5. Abort in WAIT: AS high before DSACK (WAIT_STATES=8) -> no DSACK, oe drops next clock, hit_count unchanged.
6. Reset mid-ACK: pin_reset_in low -> dsack=1, oe=0 asynchronously; next read of a previously written index returns 0.
